// File: rtl/ycbcr_pattern_stream_buffer.sv
// Pattern RAM with a banded YCbCr self-fill, a host write port and a
// valid/ready sample stream feeding the YCbCr-to-RGB path.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_INIT   | fill RAM with the band pattern, one word per cycle, host blocked
// ST_IDLE   | host writes accepted, waiting for stream_start / init_req
// ST_STREAM | reading base..base+len-1 (mod DEPTH) through a 2-entry skid buffer
//
// BAND_LOG2 must be in 1..ADDR_WIDTH.
module ycbcr_pattern_stream_buffer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int BAND_LOG2  = 3,
    parameter logic [(2**BAND_LOG2)*DATA_WIDTH-1:0] BAND_VALUES = 64'h22359090F05A5151
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  stream_start,
    input  logic [ADDR_WIDTH-1:0] stream_base,
    input  logic [ADDR_WIDTH:0]   stream_len,
    output logic                  stream_busy,
    output logic                  stream_done,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_valid,
    input  logic                  s_ready
);

    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int NUM_BANDS = 2**BAND_LOG2;
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [NUM_BANDS-1:0][DATA_WIDTH-1:0] BAND_TABLE = BAND_VALUES;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic                  init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    // words still to be read from the RAM / still to be accepted by the sink
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   accept_cnt_q, accept_cnt_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BAND_LOG2-1:0]  fill_band;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  accept;
    logic                  abort;
    logic [2:0]            occ_net;
    logic                  rd_en;

    assign init_busy   = (state_q == ST_INIT);
    assign wr_ready    = (state_q != ST_INIT);
    assign stream_busy = (state_q == ST_STREAM);
    assign init_done   = init_done_q;
    assign s_valid     = (buf_cnt_q != 2'd0);
    assign s_data      = buf0_q;

    assign fill_band   = fill_addr_q[ADDR_WIDTH-1 -: BAND_LOG2];
    assign len_clamped = (stream_len > DEPTH_LEN) ? DEPTH_LEN : stream_len;
    assign abort       = (state_q == ST_STREAM) && init_req;
    assign accept      = s_valid && s_ready;
    // An accept racing an abort is not a completion: the stream is discarded.
    assign stream_done = accept && !init_req && (accept_cnt_q == (ADDR_WIDTH+1)'(1));

    // Occupancy counts the word leaving this cycle, so a read can be issued
    // while the head drains; this keeps the stream bubble-free at s_ready=1.
    assign occ_net = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, accept};
    assign rd_en   = (state_q == ST_STREAM) && !init_req &&
                     (issue_cnt_q != '0) && (occ_net < 3'd2);

    // Write port mux: the fill owns the RAM in INIT, the host otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = fill_addr_q;
            mem_wdata = BAND_TABLE[fill_band];
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Simple dual-port RAM, synchronous read; a same-address write returns old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr_q];
        end
    end

    // Control FSM: fill sequencing, stream setup, read address and word counters.
    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        init_done_d  = 1'b0;
        rd_addr_d    = rd_addr_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        case (state_q)
            ST_INIT: begin
                fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
                if (&fill_addr_q) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d     = ST_INIT;
                    fill_addr_d = '0;
                end else if (stream_start && (stream_len != '0)) begin
                    state_d      = ST_STREAM;
                    rd_addr_d    = stream_base;
                    issue_cnt_d  = len_clamped;
                    accept_cnt_d = len_clamped;
                end
            end
            ST_STREAM: begin
                if (init_req) begin
                    state_d     = ST_INIT;
                    fill_addr_d = '0;
                end else begin
                    if (rd_en) begin
                        rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
                        issue_cnt_d = issue_cnt_q - (ADDR_WIDTH+1)'(1);
                    end
                    if (accept) begin
                        accept_cnt_d = accept_cnt_q - (ADDR_WIDTH+1)'(1);
                        if (accept_cnt_q == (ADDR_WIDTH+1)'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_INIT;
                fill_addr_d = '0;
            end
        endcase
    end

    // Skid buffer: push the word returning from the RAM, pop on accept.
    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        inflight_d = rd_en;
        if (abort) begin
            buf_cnt_d  = 2'd0;
            inflight_d = 1'b0;
        end else if (inflight_q && accept) begin
            if (buf_cnt_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = rd_data_q;
            end else begin
                buf0_d = rd_data_q;
            end
        end else if (accept) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end else if (inflight_q) begin
            if (buf_cnt_q == 2'd0) begin
                buf0_d = rd_data_q;
            end else begin
                buf1_d = rd_data_q;
            end
            buf_cnt_d = buf_cnt_q + 2'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            fill_addr_q  <= '0;
            init_done_q  <= 1'b0;
            rd_addr_q    <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            buf_cnt_q    <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            init_done_q  <= init_done_d;
            rd_addr_q    <= rd_addr_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            buf_cnt_q    <= buf_cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            inflight_q   <= inflight_d;
        end
    end

endmodule

// File: tb/tb_ycbcr_pattern_stream_buffer.sv
// Bench for ycbcr_pattern_stream_buffer: a memory-image model predicts every
// streamed word; literal expectations pin the band layout and timing.
module tb_ycbcr_pattern_stream_buffer;

    localparam logic [63:0] BV = 64'h22359090F05A5151;

    logic       clk;
    logic       rst_n;
    logic       init_req;
    logic       init_busy;
    logic       init_done;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       stream_start;
    logic [8:0] stream_base;
    logic [9:0] stream_len;
    logic       stream_busy;
    logic       stream_done;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    logic       sm_init_req;
    logic       sm_init_busy;
    logic       sm_init_done;
    logic       sm_wr_en;
    logic [5:0] sm_wr_addr;
    logic [7:0] sm_wr_data;
    logic       sm_wr_ready;
    logic       sm_stream_start;
    logic [5:0] sm_stream_base;
    logic [6:0] sm_stream_len;
    logic       sm_stream_busy;
    logic       sm_stream_done;
    logic [7:0] sm_s_data;
    logic       sm_s_valid;
    logic       sm_s_ready;

    ycbcr_pattern_stream_buffer u_dut (
        .clk(clk), .rst_n(rst_n),
        .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .stream_start(stream_start), .stream_base(stream_base), .stream_len(stream_len),
        .stream_busy(stream_busy), .stream_done(stream_done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
    );

    ycbcr_pattern_stream_buffer #(
        .ADDR_WIDTH(6), .DATA_WIDTH(8), .BAND_LOG2(1), .BAND_VALUES(16'h8010)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n),
        .init_req(sm_init_req), .init_busy(sm_init_busy), .init_done(sm_init_done),
        .wr_en(sm_wr_en), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data), .wr_ready(sm_wr_ready),
        .stream_start(sm_stream_start), .stream_base(sm_stream_base), .stream_len(sm_stream_len),
        .stream_busy(sm_stream_busy), .stream_done(sm_stream_done),
        .s_data(sm_s_data), .s_valid(sm_s_valid), .s_ready(sm_s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [7:0] model_mem [512];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data;

    int         pin_idx [11] = '{0, 127, 128, 191, 192, 255, 256, 383, 384, 448, 511};
    logic [7:0] pin_val [11] = '{8'h51, 8'h51, 8'h5a, 8'h5a, 8'hf0, 8'hf0,
                                 8'h90, 8'h90, 8'h35, 8'h22, 8'h22};

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Pattern image: eight bands of 64 words, band b taking byte b of BV.
    function automatic void model_fill();
        for (int a = 0; a < 512; a++) begin
            model_mem[a] = 8'((BV >> ((a / 64) * 8)) & 64'hff);
        end
    endfunction

    // Stream scoreboard, evaluated mid-cycle; an accept happens at the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && !init_req) begin
                check("stall_valid", s_valid, 1);
                check("stall_data", s_data, hold_data);
            end
            check("done_exclusive", init_done & stream_done, 0);
            check("no_unexpected_valid", s_valid && (exp_q.size() == 0), 0);
            if (s_valid && s_ready && !init_req && exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("stream_data", s_data, e);
                check("stream_done_last", stream_done, exp_q.size() == 0);
                got_q.push_back(s_data);
                acc_cnt++;
            end else begin
                check("stream_done_idle", stream_done, 0);
            end
            hold_pending = s_valid && !s_ready && !init_req;
            hold_data    = s_data;
        end
    end

    task automatic check_reset_vals(input string nm);
        check({nm, "_init_busy"}, init_busy, 1);
        check({nm, "_init_done"}, init_done, 0);
        check({nm, "_wr_ready"}, wr_ready, 0);
        check({nm, "_stream_busy"}, stream_busy, 0);
        check({nm, "_stream_done"}, stream_done, 0);
        check({nm, "_s_valid"}, s_valid, 0);
        check({nm, "_s_data"}, s_data, 0);
    endtask

    // Called with the first counted cycle being the one before the first fill write.
    task automatic wait_init(input string nm);
        int cnt = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (init_busy) cnt++;
            else begin
                seen = init_done;
                break;
            end
        end
        check({nm, "_busy_cycles"}, cnt, 512);
        check({nm, "_done_pulse"}, seen, 1);
    endtask

    task automatic host_write(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[8:0];
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic start_stream(input int base, input int len);
        int n;
        n = (len > 512) ? 512 : len;
        got_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(base + i) % 512]);
        stream_base  = base[8:0];
        stream_len   = len[9:0];
        stream_start = 1'b1;
        @(posedge clk); #1;
        stream_start = 1'b0;
        check("lat_cycle0", s_valid, 0);
        @(posedge clk); #1;
        check("lat_cycle1", s_valid, 0);
        @(posedge clk); #1;
        check("lat_cycle2", s_valid, 1);
    endtask

    task automatic run_stream(input string nm, input int budget, input bit toggle);
        bit fin = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (toggle) s_ready = (c % 3 == 0);
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !stream_busy) begin
                fin = 1'b1;
                break;
            end
        end
        check({nm, "_finished"}, fin, 1);
        check({nm, "_valid_low"}, s_valid, 0);
        s_ready = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        rst_n = 1'b0;
        init_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        stream_start = 1'b0; stream_base = '0; stream_len = '0; s_ready = 1'b0;
        sm_init_req = 1'b0; sm_wr_en = 1'b0; sm_wr_addr = '0; sm_wr_data = '0;
        sm_stream_start = 1'b0; sm_stream_base = '0; sm_stream_len = '0; sm_s_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        model_fill();
        wait_init("init0");
        @(posedge clk); #1;
        check("idle_wr_ready", wr_ready, 1);

        // full-memory stream of the power-up pattern
        s_ready = 1'b1;
        start_stream(0, 512);
        run_stream("full", 700, 1'b0);
        check("full_count", got_q.size(), 512);
        for (int i = 0; i < 11; i++) check("full_pin", got_q[pin_idx[i]], pin_val[i]);

        // host writes then a short stream over them
        host_write(5, 8'hAB);
        host_write(6, 8'hCD);
        start_stream(4, 4);
        run_stream("short", 50, 1'b0);
        check("short_w0", got_q[0], 8'h51);
        check("short_w1", got_q[1], 8'hAB);
        check("short_w2", got_q[2], 8'hCD);
        check("short_w3", got_q[3], 8'h51);

        // wrap from the top of memory to address 0
        start_stream(508, 8);
        run_stream("wrap", 50, 1'b0);
        check("wrap_w3", got_q[3], 8'h22);
        check("wrap_w4", got_q[4], 8'h51);

        // distinct words streamed under 1,0,0 backpressure
        for (int i = 0; i < 16; i++) host_write(300 + i, 8'(i * 7 + 3));
        start_stream(300, 16);
        run_stream("stall", 200, 1'b1);
        check("stall_count", got_q.size(), 16);
        check("stall_w15", got_q[15], 8'd108);

        // abort after 5 accepts; host writes during the refill are dropped
        host_write(16, 8'h77);
        start_stream(16, 16);
        a0 = acc_cnt - 0;
        a0 = acc_cnt;
        for (int c = 0; c < 50; c++) begin
            if (acc_cnt - a0 >= 5) break;
            @(posedge clk); #1;
        end
        check("abort_accepts", acc_cnt - a0, 5);
        check("abort_first_word", got_q[0], 8'h77);
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        exp_q.delete();
        check("abort_valid", s_valid, 0);
        check("abort_busy", stream_busy, 0);
        check("abort_init_busy", init_busy, 1);
        check("abort_wr_ready", wr_ready, 0);
        wr_en = 1'b1; wr_addr = 9'h020; wr_data = 8'hEE;
        model_fill();
        wait_init("refill");
        wr_en = 1'b0;
        @(posedge clk); #1;
        start_stream(16, 17);
        run_stream("after_refill", 60, 1'b0);
        check("refill_0x10", got_q[0], 8'h51);
        check("refill_0x20", got_q[16], 8'h51);

        // reset mid-fill at fill_addr 200
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("fill_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_fill();
        wait_init("fill_rst_init");
        @(posedge clk); #1;

        // reset while a stalled stream holds a word
        s_ready = 1'b0;
        start_stream(0, 64);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", s_valid, 1);
        check("pre_rst_busy", stream_busy, 1);
        check("pre_rst_data", s_data, 8'h51);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals("stream_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_ready = 1'b1;
        model_fill();
        wait_init("stream_rst_init");
        @(posedge clk); #1;

        // 64-word variant; stream_len 100 clamps to the depth
        sm_s_ready = 1'b1;
        sm_stream_base = 6'd0;
        sm_stream_len = 7'd100;
        sm_stream_start = 1'b1;
        @(posedge clk); #1;
        sm_stream_start = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sm_s_valid && sm_s_ready) begin
                check("small_data", sm_s_data, (n < 32) ? 8'h10 : 8'h80);
                check("small_done", sm_stream_done, n == 63);
                n++;
            end
        end
        check("small_count", n, 64);
        check("small_busy_end", sm_stream_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ycbcr_pattern_stream_buffer.md
Name: ycbcr_pattern_stream_buffer

Overview:
Parametrised successor to the fixed 512x8 YCbCr pattern RAM. The memory holds DEPTH = 2**ADDR_WIDTH words. An init FSM fills it with a programmable banded YCbCr test pattern after reset or on request. It has a host write port and a streaming read port with valid/ready backpressure. The block sits between the pattern/host logic and the YCbCr-to-RGB conversion path, and feeds it a continuous sample stream.

Parameters:
ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH.
DATA_WIDTH, 8, sample width.
BAND_LOG2, 3, log2 of band count; NUM_BANDS = 2**BAND_LOG2; each band spans DEPTH/NUM_BANDS words. Must satisfy BAND_LOG2 <= ADDR_WIDTH.
BAND_VALUES, 64'h22359090F05A5151, NUM_BANDS*DATA_WIDTH packed fill values; band 0 is in the LSBs.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
init_req  in  1  pulse: refill memory with the pattern.
init_busy  out  1  high while the fill runs.
init_done  out  1  one-cycle pulse after the last fill write.
wr_en  in  1  host write strobe.
wr_addr  in  ADDR_WIDTH  host write address.
wr_data  in  DATA_WIDTH  host write data.
wr_ready  out  1  host writes accepted (0 during fill).
stream_start  in  1  pulse: begin a stream.
stream_base  in  ADDR_WIDTH  first stream address.
stream_len  in  ADDR_WIDTH+1  word count, 1..DEPTH.
stream_busy  out  1  stream in progress.
stream_done  out  1  one-cycle pulse when the last word is accepted.
s_data  out  DATA_WIDTH  stream sample.
s_valid  out  1  s_data valid.
s_ready  in  1  consumer ready.

Behaviour:
- Storage: simple dual-port, synchronous read, 1-cycle read latency. Same-address write and read in one cycle returns the old data (read-before-write).
- Reset values while rst_n=0: init_busy=1, init_done=0, wr_ready=0, stream_busy=0, stream_done=0, s_valid=0, s_data=0. FSM state is INIT with fill_addr=0. Memory contents are undefined.
- FSM states are INIT, IDLE and STREAM.
- INIT:
  - Writes BAND_VALUES[band] to fill_addr, one word per cycle. band = fill_addr[ADDR_WIDTH-1 -: BAND_LOG2].
  - Exactly DEPTH cycles. The first write occurs on the first rising edge after rst_n deasserts.
  - After the write to DEPTH-1: init_done pulses and the FSM enters IDLE.
  - init_busy=1 and wr_ready=0 throughout. wr_en, stream_start and init_req are ignored.
- IDLE:
  - wr_ready=1. wr_en writes wr_data to wr_addr.
  - stream_start with stream_len != 0 latches base and length, then enters STREAM. stream_start with stream_len == 0 is ignored.
  - stream_len > DEPTH is clamped to DEPTH.
  - init_req enters INIT with fill_addr=0. init_req and stream_start in the same cycle: init_req wins.
- STREAM:
  - stream_busy=1 and wr_ready=1; host writes proceed concurrently.
  - Read address starts at base and increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - Output is a 2-entry skid buffer. A RAM read is issued only when (buffered + in-flight) < 2 and words remain to issue.
  - With s_ready held high: first s_valid 2 cycles after stream_start, then one word per cycle with no bubbles.
  - With s_valid=1 and s_ready=0: s_data and s_valid hold stable. No word is dropped or duplicated.
  - A word is accepted on s_valid & s_ready. On acceptance of the final word: stream_done pulses the same cycle, and the FSM returns to IDLE on the next cycle with s_valid=0.
  - stream_start is ignored while in STREAM.
  - init_req aborts the stream: skid buffer flushed, s_valid=0 next cycle, stream_busy=0, no stream_done, enter INIT.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), and the fill restarts from address 0 after release.
- init_done and stream_done never assert in the same cycle.

Test Plan:
1. Default parameters, release reset → init_busy high for exactly 512 cycles, then init_done pulses. Stream base 0, len 512, s_ready=1 → words 0-127=0x51, 128-191=0x5a, 192-255=0xf0, 256-383=0x90, 384-447=0x35, 448-511=0x22.
2. In IDLE write 0xAB@5, 0xCD@6; stream base 4, len 4 → 0x51, 0xAB, 0xCD, 0x51; stream_done on the 4th accept; first s_valid 2 cycles after start.
3. Stream base 508, len 8 → addresses 508..511, 0..3 → 0x22 x4, 0x51 x4 (wrap correct).
4. Stream len 16 with s_ready toggling 1,0,0,1,… → s_data stable while stalled; exactly 16 accepts, in order, no duplicates.
5. init_req mid-stream after 5 accepts → s_valid=0 next cycle, no stream_done, 512-cycle refill, init_done pulses; a prior host write to 0x10 now reads back 0x51. wr_en during the fill has no effect.
6. rst_n low for 3 cycles at fill_addr=200 → outputs take reset values asynchronously; after release the fill takes a full 512 cycles; parameter variant ADDR_WIDTH=6, BAND_LOG2=1, BAND_VALUES=16'h8010 → addresses 0-31=0x10, 32-63=0x80.
